vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed 640x480 timing/pixel-coordinate logic. All porch, sync and active widths are parameters, and sync polarity is selectable. It issues pixel requests with coordinates a configurable number of cycles ahead, so pixel sources with pipeline latency (ROM, font, key-graphic renderers) line up with sync and data-enable. It sits between the 25 MHz clock divider and the board VGA pins, replacing the previous driver path.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_delay_line.sv | 38 +++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel width, RGB444 colour constants, default
// 640x480@60 timing and a sync-level helper.
package vga_pkg;

  localparam int PIX_W = 12;

  typedef logic [PIX_W-1:0] rgb_t;

  localparam rgb_t RGB_BLACK  = 12'h000;
  localparam rgb_t RGB_WHITE  = 12'hFFF;
  localparam rgb_t RGB_RED    = 12'hF00;
  localparam rgb_t RGB_GREEN  = 12'h0F0;
  localparam rgb_t RGB_BLUE   = 12'h00F;
  localparam rgb_t RGB_YELLOW = 12'hFF0;
  localparam rgb_t RGB_CYAN   = 12'h0FF;
  localparam rgb_t RGB_GREY   = 12'h888;

  // 640x480@60 with a 25 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 29;

  // Pin level for a sync signal given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of configurable width/depth with async
// active-low clear. DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift one stage per enabled clock; clear forces every stage to zero.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= {WIDTH{1'b0}};
          end
        end else if (en) begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Issues pixel requests PIPE_DLY+1
// clocks ahead of hsync/vsync/de/rgb so a pipelined pixel source lines up.
// Optional frame counter is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIPE_DLY = 1,
  parameter int   CNT_W    = 10
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             en,
  input  logic [PIX_W-1:0] pix_data_in,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [PIX_W-1:0] rgb,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_VIS_BEG = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_VIS_BEG = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] H_VIS_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  logic [CNT_W-1:0] hc_r;
  logic [CNT_W-1:0] vc_r;

  logic             req_s;
  logic [CNT_W-1:0] x_s;
  logic [CNT_W-1:0] y_s;
  logic [2:0]       raw_s;      // {hsync active, vsync active, de}
  logic [2:0]       raw_r;
  logic [2:0]       raw_dly_s;

  // Raster position: hc sweeps a line, vc advances on each line wrap.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      hc_r <= CNT_ZERO;
      vc_r <= CNT_ZERO;
    end else if (en) begin
      if (hc_r == H_LAST) begin
        hc_r <= CNT_ZERO;
        vc_r <= (vc_r == V_LAST) ? CNT_ZERO : vc_r + CNT_ONE;
      end else begin
        hc_r <= hc_r + CNT_ONE;
      end
    end
  end

  // Decode the current position into request/coordinate/raw sync values.
  always_comb begin
    req_s = (hc_r >= H_VIS_BEG) && (hc_r < H_VIS_END) &&
            (vc_r >= V_VIS_BEG) && (vc_r < V_VIS_END);
    x_s   = req_s ? (hc_r - H_VIS_BEG) : {CNT_W{1'b1}};
    y_s   = req_s ? (vc_r - V_VIS_BEG) : {CNT_W{1'b1}};
    raw_s = {(hc_r < H_SYN_END), (vc_r < V_SYN_END), req_s};
  end

  // Request stage: everything the pixel source sees, plus the raw timing bits.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      pix_req     <= 1'b0;
      pix_x       <= {CNT_W{1'b1}};
      pix_y       <= {CNT_W{1'b1}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      raw_r       <= 3'b000;
    end else if (en) begin
      pix_req     <= req_s;
      pix_x       <= x_s;
      pix_y       <= y_s;
      line_start  <= (hc_r == CNT_ZERO);
      frame_start <= (hc_r == CNT_ZERO) && (vc_r == CNT_ZERO);
      raw_r       <= raw_s;
    end
  end

  // Raw bits are stored as "asserted" flags so a cleared line means inactive.
  vga_delay_line #(
    .WIDTH(3),
    .DEPTH(PIPE_DLY)
  ) u_dly (
    .clk (clk25),
    .rst (rst),
    .en  (en),
    .d   (raw_r),
    .q   (raw_dly_s)
  );

  // Output stage: apply sync polarity and gate pixel data with the delayed de.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      de    <= 1'b0;
      rgb   <= 12'h000;
    end else if (en) begin
      hsync <= sync_level(raw_dly_s[2], HS_POL);
      vsync <= sync_level(raw_dly_s[1], VS_POL);
      de    <= raw_dly_s[0];
      rgb   <= raw_dly_s[0] ? pix_data_in : 12'h000;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Count frames on each enabled clock that carries the frame_start pulse.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      frame_cnt_r <= 16'h0000;
    end else if (en && frame_start) begin
      frame_cnt_r <= frame_cnt_r + 16'h0001;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance checked against a
// table of cycle checkpoints, and a tiny-raster instance (PIPE_DLY=3) checked
// every cycle against a model through an expected-output queue.
module tb_vga_timing_gen;

  logic clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic        rst_d = 1'b1;
  logic        en_d  = 1'b1;
  logic [11:0] d_pix_data_in = 12'hABC;
  logic        d_pix_req, d_ls, d_fs, d_hsync, d_vsync, d_de;
  logic [9:0]  d_pix_x, d_pix_y;
  logic [11:0] d_rgb;
  logic [15:0] d_frame_cnt;

  vga_timing_gen u_def (
    .clk25(clk25), .rst(rst_d), .en(en_d), .pix_data_in(d_pix_data_in),
    .pix_req(d_pix_req), .pix_x(d_pix_x), .pix_y(d_pix_y),
    .line_start(d_ls), .frame_start(d_fs), .hsync(d_hsync), .vsync(d_vsync),
    .de(d_de), .rgb(d_rgb), .frame_cnt(d_frame_cnt)
  );

  // ---------------- tiny-raster instance ----------------
  logic        rst_s = 1'b1;
  logic        en_s  = 1'b0;
  logic [11:0] s_pix_data_in;
  logic        s_pix_req, s_ls, s_fs, s_hsync, s_vsync, s_de;
  logic [9:0]  s_pix_x, s_pix_y;
  logic [11:0] s_rgb;
  logic [15:0] s_frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(3), .CNT_W(10)
  ) u_small (
    .clk25(clk25), .rst(rst_s), .en(en_s), .pix_data_in(s_pix_data_in),
    .pix_req(s_pix_req), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .line_start(s_ls), .frame_start(s_fs), .hsync(s_hsync), .vsync(s_vsync),
    .de(s_de), .rgb(s_rgb), .frame_cnt(s_frame_cnt)
  );

  // Pixel source with 3 clocks of latency: returns {2'b0, x}, 0xFFF in blanking.
  logic [2:0] src_req_r;
  logic [9:0] src_x_r [3];
  always @(posedge clk25 or negedge rst_s) begin
    if (!rst_s) begin
      src_req_r <= 3'b000;
      for (int i = 0; i < 3; i++) src_x_r[i] <= 10'h000;
    end else if (en_s) begin
      src_req_r  <= {src_req_r[1:0], s_pix_req};
      src_x_r[0] <= s_pix_x;
      src_x_r[1] <= src_x_r[0];
      src_x_r[2] <= src_x_r[1];
    end
  end
  assign s_pix_data_in = src_req_r[2] ? {2'b00, src_x_r[2]} : 12'hFFF;

  // ---------------- model of the tiny raster ----------------
  typedef struct packed {
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } pix_t;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
  } out_t;

  int    hc_m, vc_m;
  pix_t  last_pix;
  out_t  last_out;
  out_t  sb_q[$];
  logic [15:0] fc_m;

  function automatic pix_t pix_exp(input int hc, input int vc);
    pix_t p;
    p.req = (hc >= 3) && (hc < 7) && (vc >= 2) && (vc < 5);
    p.x   = p.req ? 10'(hc - 3) : 10'h3FF;
    p.y   = p.req ? 10'(vc - 2) : 10'h3FF;
    p.ls  = (hc == 0);
    p.fs  = (hc == 0) && (vc == 0);
    return p;
  endfunction

  function automatic out_t out_exp(input int hc, input int vc);
    out_t o;
    logic req;
    req   = (hc >= 3) && (hc < 7) && (vc >= 2) && (vc < 5);
    o.hs  = (hc < 2);                 // active-high hsync
    o.vs  = (vc < 1) ? 1'b0 : 1'b1;   // active-low vsync
    o.de  = req;
    o.rgb = req ? {2'b00, 10'(hc - 3)} : 12'h000;
    return o;
  endfunction

  localparam out_t OUT_IDLE = '{1'b0, 1'b1, 1'b0, 12'h000};
  localparam pix_t PIX_IDLE = '{1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0};

  task automatic reset_model();
    hc_m = 0;
    vc_m = 0;
    sb_q.delete();
    for (int i = 0; i < 4; i++) sb_q.push_back(OUT_IDLE);
    last_pix = PIX_IDLE;
    last_out = OUT_IDLE;
    fc_m     = 16'h0000;
  endtask

  int tick_no;
  logic count_on = 1'b0;
  int hs_cnt = 0, de_cnt = 0, fs_cnt = 0, fs_per = 0, last_fs_tick = -1;

  task automatic cmp_small();
    chk("s_pix_req",     32'(s_pix_req),   32'(last_pix.req));
    chk("s_pix_x",       32'(s_pix_x),     32'(last_pix.x));
    chk("s_pix_y",       32'(s_pix_y),     32'(last_pix.y));
    chk("s_line_start",  32'(s_ls),        32'(last_pix.ls));
    chk("s_frame_start", 32'(s_fs),        32'(last_pix.fs));
    chk("s_hsync",       32'(s_hsync),     32'(last_out.hs));
    chk("s_vsync",       32'(s_vsync),     32'(last_out.vs));
    chk("s_de",          32'(s_de),        32'(last_out.de));
    chk("s_rgb",         32'(s_rgb),       32'(last_out.rgb));
    chk("s_frame_cnt",   32'(s_frame_cnt), 32'(fc_m));
  endtask

  // One clock of the tiny raster: advance the model when enabled, then compare.
  task automatic tick_s();
    logic en_v;
    en_v = en_s;
    @(posedge clk25);
    #1;
    tick_no++;
    if (en_v) begin
`ifdef VGA_FRAME_CNT_EN
      if (last_pix.fs) fc_m = fc_m + 16'h0001;
`endif
      last_pix = pix_exp(hc_m, vc_m);
      sb_q.push_back(out_exp(hc_m, vc_m));
      if (sb_q.size() > 4) last_out = sb_q.pop_front();
      hc_m++;
      if (hc_m == 8) begin
        hc_m = 0;
        vc_m++;
        if (vc_m == 6) vc_m = 0;
      end
    end
    cmp_small();
    if (count_on) begin
      if (s_hsync) hs_cnt++;
      if (s_de) de_cnt++;
      if (s_fs) begin
        fs_cnt++;
        if (last_fs_tick >= 0) fs_per = tick_no - last_fs_tick;
        last_fs_tick = tick_no;
      end
    end
  endtask

  // ---------------- checkpoint table for the default instance ----------------
  typedef struct {
    int         k;      // clocks since reset release
    logic       req;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       de;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];
  int   cyc_d = 0;

  initial begin
    tbl[0]  = '{0,     1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1,     1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{2,     1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{3,     1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{98,    1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{99,    1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1601,  1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1603,  1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{24944, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{24945, 1'b1, 10'd0,   10'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{24947, 1'b1, 10'd2,   10'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{25584, 1'b1, 10'd639, 10'd0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{25585, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{25587, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{25601, 1'b0, 10'h3FF, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{25603, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{25745, 1'b1, 10'd0,   10'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{25746, 1'b1, 10'd1,   10'd1,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    #2;
    rst_d = 1'b0;
    rst_s = 1'b0;
    #3;

    // Default instance: walk the checkpoints; entry 0 is the reset state.
    for (int i = 0; i < NV; i++) begin
      while (cyc_d < tbl[i].k) begin
        @(posedge clk25);
        #1;
        cyc_d++;
      end
      chk("d_pix_req",     32'(d_pix_req), 32'(tbl[i].req));
      chk("d_pix_x",       32'(d_pix_x),   32'(tbl[i].x));
      chk("d_pix_y",       32'(d_pix_y),   32'(tbl[i].y));
      chk("d_line_start",  32'(d_ls),      32'(tbl[i].ls));
      chk("d_frame_start", 32'(d_fs),      32'(tbl[i].fs));
      chk("d_hsync",       32'(d_hsync),   32'(tbl[i].hs));
      chk("d_vsync",       32'(d_vsync),   32'(tbl[i].vs));
      chk("d_de",          32'(d_de),      32'(tbl[i].de));
      chk("d_rgb",         32'(d_rgb),     32'(tbl[i].de ? 12'hABC : 12'h000));
      if (i == 0) rst_d = 1'b1;
    end

    // Tiny raster: release reset away from a clock edge.
    en_s = 1'b1;
    #5;
    rst_s = 1'b1;
    reset_model();
    tick_no = 0;

    // Two frames; count hsync-high, de and frame_start over ticks 5..100.
    for (int i = 0; i < 100; i++) begin
      count_on = (tick_no >= 4) && (tick_no < 100);
      tick_s();
    end
    count_on = 1'b0;
    chk("hsync_high_per_2_frames", 32'(hs_cnt), 32'd24);
    chk("de_per_2_frames",         32'(de_cnt), 32'd24);
    chk("frame_start_count",       32'(fs_cnt), 32'd2);
    chk("frame_start_period",      32'(fs_per), 32'd48);

    // Stall mid-line for 10 clocks, then resume.
    for (int i = 0; i < 48 && !(vc_m == 3 && hc_m == 4); i++) tick_s();
    en_s = 1'b0;
    for (int i = 0; i < 10; i++) tick_s();
    en_s = 1'b1;
    for (int i = 0; i < 30; i++) tick_s();

    // Asynchronous reset in mid-frame: outputs must clear without a clock edge.
    for (int i = 0; i < 48 && !(vc_m == 3 && hc_m == 5); i++) tick_s();
    #3;
    rst_s = 1'b0;
    #1;
    chk("rst_pix_req",     32'(s_pix_req),   32'd0);
    chk("rst_pix_x",       32'(s_pix_x),     32'h3FF);
    chk("rst_pix_y",       32'(s_pix_y),     32'h3FF);
    chk("rst_line_start",  32'(s_ls),        32'd0);
    chk("rst_frame_start", 32'(s_fs),        32'd0);
    chk("rst_hsync",       32'(s_hsync),     32'd0);
    chk("rst_vsync",       32'(s_vsync),     32'd1);
    chk("rst_de",          32'(s_de),        32'd0);
    chk("rst_rgb",         32'(s_rgb),       32'h000);
    chk("rst_frame_cnt",   32'(s_frame_cnt), 32'h0000);
    @(posedge clk25);
    @(posedge clk25);
    #5;
    rst_s = 1'b1;
    reset_model();

    // Restart: frame_start one clock after release, then three-plus frames.
    for (int i = 0; i < 160; i++) tick_s();
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_after_frames", 32'(s_frame_cnt), 32'd4);
`else
    chk("frame_cnt_tied_off", 32'(s_frame_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
